// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard / sequencing control.
package pipe_pkg;

  localparam logic [1:0]  TUSE_NONE     = 2'd3;
  localparam logic [31:0] EXC_ENTRY     = 32'h0000_4180;
  localparam int          MULT_CYC_DEF  = 5;
  localparam int          DIV_CYC_DEF   = 10;
  localparam int          CNT_W_DEF     = 4;
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu.sv
// Tracks the multi-cycle mult/div unit: start gating, busy countdown, busy flag.
module mdu_busy_tracker
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_md_go,
  input  logic             e_md_div,
  input  logic             req,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic             md_state_dbg
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  mdu_state_e state;

  // md_start is a one-cycle request with no back-pressure: the MDU always accepts
  // it when idle. A go that arrives while busy is dropped (no reload).
  assign md_start     = e_md_go & ~req;
  assign md_busy      = (md_cnt != '0) | md_start;
  assign md_state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MDU_IDLE;
      md_cnt <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (md_start) begin
            md_cnt <= e_md_div ? DIV_LD : MULT_LD;
            state  <= MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          // req deliberately ignored: the issuing instr already committed.
          md_cnt <= md_cnt - ONE;
          if (md_cnt == ONE) state <= MDU_IDLE;
        end
        default: begin
          state  <= MDU_IDLE;
          md_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// D-stage stall / exception flush sequencer for the 5-stage core, with a
// saturating stalled-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int          MULT_CYC      = MULT_CYC_DEF,
  parameter int          DIV_CYC       = DIV_CYC_DEF,
  parameter int          CNT_W         = CNT_W_DEF,
  parameter logic [31:0] STALL_CNT_RST = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_waddr,
  input  logic [1:0]       e_tnew,
  input  logic [4:0]       m_waddr,
  input  logic [1:0]       m_tnew,
  input  logic             e_md_go,
  input  logic             e_md_div,
  input  logic             m_req,
  output logic             stall,
  output logic             req,
  output logic             pc_we,
  output logic             d_we,
  output logic             md_start,
  output logic             md_busy,
  output logic [31:0]      stall_cnt,
  output logic [CNT_W-1:0] md_cnt_dbg,
  output logic             md_state_dbg
);

  logic h_rs;
  logic h_rt;
  logic stall_raw;

  // A source hazards when a younger-needed operand is still being produced.
  // Register 0 never hazards; TUSE_NONE (3) can never be below any tnew.
  assign h_rs = (d_rs != 5'd0) &
                (((d_rs == e_waddr) & (d_tuse_rs < e_tnew)) |
                 ((d_rs == m_waddr) & (d_tuse_rs < m_tnew)));
  assign h_rt = (d_rt != 5'd0) &
                (((d_rt == e_waddr) & (d_tuse_rt < e_tnew)) |
                 ((d_rt == m_waddr) & (d_tuse_rt < m_tnew)));

  assign req       = m_req;
  assign stall_raw = h_rs | h_rt | (d_is_md & md_busy);
  assign stall     = stall_raw & ~req;
  assign pc_we     = ~stall;
  assign d_we      = ~stall;

  mdu_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_mdu (
    .clk          (clk),
    .reset        (reset),
    .e_md_go      (e_md_go),
    .e_md_div     (e_md_div),
    .req          (req),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .md_cnt       (md_cnt_dbg),
    .md_state_dbg (md_state_dbg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= STALL_CNT_RST;
    end else if (stall && (stall_cnt != STALL_CNT_MAX)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: operand hazards, MDU busy, exception priority,
// reset abort and stall counter saturation.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_waddr, m_waddr;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_go, e_md_div, m_req;

  logic        stall, req, pc_we, d_we, md_start, md_busy, md_state;
  logic [31:0] stall_cnt;
  logic [3:0]  md_cnt;

  logic        stall2, req2, pc_we2, d_we2, md_start2, md_busy2, md_state2;
  logic [31:0] stall_cnt2;
  logic [3:0]  md_cnt2;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_sc = 32'd0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_waddr(e_waddr), .e_tnew(e_tnew), .m_waddr(m_waddr), .m_tnew(m_tnew),
    .e_md_go(e_md_go), .e_md_div(e_md_div), .m_req(m_req),
    .stall(stall), .req(req), .pc_we(pc_we), .d_we(d_we),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt),
    .md_cnt_dbg(md_cnt), .md_state_dbg(md_state)
  );

  // Second instance starts its counter next to the ceiling to exercise saturation.
  pipe_hazard_ctrl #(.STALL_CNT_RST(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_waddr(e_waddr), .e_tnew(e_tnew), .m_waddr(m_waddr), .m_tnew(m_tnew),
    .e_md_go(e_md_go), .e_md_div(e_md_div), .m_req(m_req),
    .stall(stall2), .req(req2), .pc_we(pc_we2), .d_we(d_we2),
    .md_start(md_start2), .md_busy(md_busy2), .stall_cnt(stall_cnt2),
    .md_cnt_dbg(md_cnt2), .md_state_dbg(md_state2)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    d_rs = 5'd0; d_rt = 5'd0;
    d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
    d_is_md = 1'b0;
    e_waddr = 5'd0; e_tnew = 2'd0;
    m_waddr = 5'd0; m_tnew = 2'd0;
    e_md_go = 1'b0; e_md_div = 1'b0; m_req = 1'b0;
  endtask

  task automatic check_ctrl(input string tag, input logic exp_stall);
    check({tag, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
    check({tag, "_pc_we"}, {31'd0, pc_we}, {31'd0, ~exp_stall});
    check({tag, "_d_we"},  {31'd0, d_we},  {31'd0, ~exp_stall});
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    tick();
    check("rst_stall",    {31'd0, stall},    32'd0);
    check("rst_req",      {31'd0, req},      32'd0);
    check("rst_pc_we",    {31'd0, pc_we},    32'd1);
    check("rst_d_we",     {31'd0, d_we},     32'd1);
    check("rst_md_start", {31'd0, md_start}, 32'd0);
    check("rst_md_busy",  {31'd0, md_busy},  32'd0);
    check("rst_md_cnt",   {28'd0, md_cnt},   32'd0);
    check("rst_sc",       stall_cnt,         32'd0);
    check("rst_sc_sat",   stall_cnt2,        32'hFFFF_FFFE);
    tick();
    reset = 1'b0;

    // lw $1 in E, addu in D needs rs next cycle
    e_waddr = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd1;
    #1 check_ctrl("lw_use", 1'b1);
    tick(); exp_sc++;
    check("lw_use_sc", stall_cnt, exp_sc);
    check("lw_use_sc_sat", stall_cnt2, 32'hFFFF_FFFF);
    e_tnew = 2'd1;
    #1 check_ctrl("lw_resolved", 1'b0);
    tick();
    check("lw_resolved_sc", stall_cnt, exp_sc);

    // rt hazard against M stage
    drive_idle();
    d_rt = 5'd5; d_tuse_rt = 2'd0; m_waddr = 5'd5; m_tnew = 2'd1;
    #1 check_ctrl("rt_m_haz", 1'b1);
    tick(); exp_sc++;
    check("rt_m_haz_sc", stall_cnt, exp_sc);

    // unused operand and tuse == tnew are not hazards
    drive_idle();
    d_rs = 5'd7; d_tuse_rs = TUSE_NONE; e_waddr = 5'd7; e_tnew = 2'd3;
    d_rt = 5'd9; d_tuse_rt = 2'd2;      m_waddr = 5'd9; m_tnew = 2'd2;
    #1 check_ctrl("no_haz", 1'b0);
    tick();

    // zero register exempt
    drive_idle();
    d_rs = 5'd0; d_tuse_rs = 2'd0; e_waddr = 5'd0; e_tnew = 2'd2;
    #1 check_ctrl("zero_reg", 1'b0);
    tick();

    // div issue with mfhi in D: 11 busy/stall cycles
    drive_idle();
    e_md_go = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      #1;
      check("div_busy", {31'd0, md_busy}, 32'd1);
      check("div_stall", {31'd0, stall}, 32'd1);
      check("div_start", {31'd0, md_start}, (i == 0) ? 32'd1 : 32'd0);
      check("div_cnt", {28'd0, md_cnt}, (i == 0) ? 32'd0 : 32'(11 - i));
      tick(); exp_sc++;
      e_md_go = 1'b0;
    end
    #1;
    check("div_done_busy",  {31'd0, md_busy},  32'd0);
    check("div_done_stall", {31'd0, stall},    32'd0);
    check("div_done_state", {31'd0, md_state}, 32'd0);
    check("div_sc", stall_cnt, exp_sc);

    // exception beats stall and blocks MDU start
    drive_idle();
    d_rs = 5'd3; d_tuse_rs = 2'd0; e_waddr = 5'd3; e_tnew = 2'd1;
    e_md_go = 1'b1; d_is_md = 1'b1; m_req = 1'b1;
    #1;
    check("exc_req",      {31'd0, req},      32'd1);
    check_ctrl("exc", 1'b0);
    check("exc_md_start", {31'd0, md_start}, 32'd0);
    check("exc_md_busy",  {31'd0, md_busy},  32'd0);
    tick();
    check("exc_md_cnt", {28'd0, md_cnt}, 32'd0);
    check("exc_sc", stall_cnt, exp_sc);

    // mult running, late go ignored, req does not abort
    drive_idle();
    e_md_go = 1'b1;
    #1 check("mul_start", {31'd0, md_start}, 32'd1);
    tick();
    e_md_go = 1'b0;
    #1 check("mul_cnt5", {28'd0, md_cnt}, 32'd5);
    check("mul_state", {31'd0, md_state}, 32'd1);
    tick();
    e_md_go = 1'b1; e_md_div = 1'b1;
    #1 check("mul_cnt4", {28'd0, md_cnt}, 32'd4);
    tick();
    e_md_go = 1'b0; e_md_div = 1'b0; m_req = 1'b1;
    #1 check("mul_cnt3_noreload", {28'd0, md_cnt}, 32'd3);
    check("mul_req", {31'd0, req}, 32'd1);
    for (int k = 2; k >= 0; k--) begin
      tick();
      check("mul_req_cnt", {28'd0, md_cnt}, 32'(k));
    end
    drive_idle();

    // reset aborts a running mult immediately
    e_md_go = 1'b1;
    tick();
    e_md_go = 1'b0;
    tick();
    tick();
    check("abort_pre_cnt", {28'd0, md_cnt}, 32'd3);
    reset = 1'b1;
    #1;
    check("abort_cnt",  {28'd0, md_cnt},  32'd0);
    check("abort_busy", {31'd0, md_busy}, 32'd0);
    check("abort_sc",   stall_cnt,        32'd0);
    check("abort_sc_sat", stall_cnt2,     32'hFFFF_FFFE);
    exp_sc = 32'd0;
    tick();
    reset = 1'b0;

    // three stall cycles: second instance saturates and holds
    e_waddr = 5'd1; e_tnew = 2'd2; d_rs = 5'd1; d_tuse_rs = 2'd0;
    for (int j = 0; j < 3; j++) begin
      #1 check("sat_stall", {31'd0, stall}, 32'd1);
      tick(); exp_sc++;
      check("sat_sc", stall_cnt, exp_sc);
      check("sat_sc_sat", stall_cnt2, 32'hFFFF_FFFF);
    end
    drive_idle();
    tick();
    check("final_sc", stall_cnt, 32'd3);
    check("final_sc_sat", stall_cnt2, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
